fg_config_sequencer: RTL and testbench

Write sequencer between the host register interface and the function generator's configuration register bank. Host writes (address, data) are queued, then applied to the bank as one atomic burst on commit. The burst only starts at a safe point: generator disabled, or the generator's period-boundary strobe. A parameter change therefore never lands mid-waveform and never splits across two periods.

---
 rtl/fg_config_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fg_config_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_config_sequencer.sv
// fg_config_sequencer
// Queues host register writes and applies them to the function generator's
// configuration bank as one uninterrupted burst after a commit. The burst
// only starts at a safe point: generator disabled or period-boundary strobe.
// That way a parameter change never lands mid-waveform.
//
// Optional feature macro: FG_CFG_TIMEOUT_EN
//   defined   - the wait for a safe point is bounded by TIMEOUT_CYCLES. On
//               expiry the burst is forced and the sticky timeout_o is set.
//   undefined - the wait is unbounded and timeout_o is tied low.
module fg_config_sequencer #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 3,
  parameter int NUM_REGS       = 7,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         req_valid_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  output logic                         req_ready_o,
  input  logic                         commit_i,
  input  logic                         fg_enable_i,
  input  logic                         period_STRB_i,
  output logic                         cr_wr_o,
  output logic [ADDR_W-1:0]            cr_addr_o,
  output logic [DATA_W-1:0]            cr_data_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_addr_o,
  output logic                         timeout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SAFE = 2'd1,
    APPLY     = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Circular buffer storage. Data only, so it carries no reset.
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              addr_ok;
  logic              req_acc;
  logic              push;
  logic              pop;
  logic              safe;

`ifdef FG_CFG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_INIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0]   to_cnt;
  logic              wait_entry;
  logic              timeout_fire;
  logic              timeout_q;
`else
  // Keeps TIMEOUT_CYCLES referenced when the timeout feature is compiled out.
  wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Request acceptance, address validity and the safe-point condition.
  always_comb begin
    addr_ok     = ({1'b0, req_addr_i} < NUM_REGS_C);
    req_ready_o = (state == IDLE) && (count < DEPTH_C);
    req_acc     = req_valid_i && req_ready_o;
    push        = req_acc && addr_ok;
    safe        = !fg_enable_i || period_STRB_i;
  end

  assign busy_o  = (state != IDLE);
  assign count_o = count;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. APPLY lingers one cycle after the last pop, so busy_o
  // stays high through the final bank write.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef FG_CFG_TIMEOUT_EN
    wait_entry   = 1'b0;
    timeout_fire = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A push in the same cycle counts toward a non-empty burst.
        if (commit_i && ((count != '0) || push)) begin
          state_nxt = WAIT_SAFE;
`ifdef FG_CFG_TIMEOUT_EN
          wait_entry = 1'b1;
`endif
        end
      end
      WAIT_SAFE: begin
        // A safe point wins over a coincident expiry.
        if (safe) begin
          state_nxt = APPLY;
        end
`ifdef FG_CFG_TIMEOUT_EN
        else if (to_cnt == '0) begin
          state_nxt    = APPLY;
          timeout_fire = 1'b1;
        end
`endif
      end
      APPLY: begin
        if (count != '0) begin
          pop = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue pointers and occupancy. Push occurs only in IDLE and pop only in
  // APPLY, but both cases are handled anyway.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr_i;
      q_data[wr_ptr] <= req_data_i;
    end
  end

  // Registered bank write port. Address and data hold between bursts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cr_wr_o   <= 1'b0;
      cr_addr_o <= '0;
      cr_data_o <= '0;
    end else begin
      cr_wr_o <= pop;
      if (pop) begin
        cr_addr_o <= q_addr[rd_ptr];
        cr_data_o <= q_data[rd_ptr];
      end
    end
  end

  // Sticky flag: an accepted request to an unimplemented register was dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_addr_o <= 1'b0;
    end else if (req_acc && !addr_ok) begin
      err_addr_o <= 1'b1;
    end
  end

`ifdef FG_CFG_TIMEOUT_EN
  // Safe-point wait counter. It is loaded on entry to WAIT_SAFE and counts
  // down while waiting.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt <= '0;
    end else if (wait_entry) begin
      to_cnt <= TO_INIT;
    end else if ((state == WAIT_SAFE) && (to_cnt != '0)) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end

  // Sticky flag: a burst was forced without a safe point.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fg_config_sequencer.sv
// tb_fg_config_sequencer
// Randomized bench for fg_config_sequencer. The reference model is a queue of
// (addr, data) entries plus the expected sticky flags. Burst timing is derived
// from the commit edge and the edge at which the safe point is presented.
module tb_fg_config_sequencer;

  localparam int DATA_W         = 8;
  localparam int ADDR_W         = 3;
  localparam int NUM_REGS       = 7;
  localparam int DEPTH          = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               req_valid_i;
  logic [ADDR_W-1:0]  req_addr_i;
  logic [DATA_W-1:0]  req_data_i;
  logic               req_ready_o;
  logic               commit_i;
  logic               fg_enable_i;
  logic               period_STRB_i;
  logic               cr_wr_o;
  logic [ADDR_W-1:0]  cr_addr_o;
  logic [DATA_W-1:0]  cr_data_o;
  logic               busy_o;
  logic [2:0]         count_o;
  logic               err_addr_o;
  logic               timeout_o;

  fg_config_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .commit_i(commit_i),
    .fg_enable_i(fg_enable_i), .period_STRB_i(period_STRB_i),
    .cr_wr_o(cr_wr_o), .cr_addr_o(cr_addr_o), .cr_data_o(cr_data_o),
    .busy_o(busy_o), .count_o(count_o),
    .err_addr_o(err_addr_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t             mq[$];
  bit                 exp_err;
  bit                 exp_to;
  logic [ADDR_W-1:0]  last_a;
  logic [DATA_W-1:0]  last_d;
  int                 n_chk;
  int                 n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit with_commit);
    bit exp_rdy;
    entry_t e;
    exp_rdy     = (mq.size() < DEPTH);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    commit_i    = with_commit;
    #1;
    check("req_ready", req_ready_o, exp_rdy);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    commit_i    = 1'b0;
    if (exp_rdy) begin
      if (int'(a) < NUM_REGS) begin
        e.a = a;
        e.d = d;
        mq.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end
    check("push_count", count_o, mq.size());
    check("push_err", err_addr_o, exp_err);
    if (with_commit) check("push_commit_busy", busy_o, mq.size() > 0);
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    check("commit_busy", busy_o, mq.size() > 0);
  endtask

  // unsafe: number of edges after commit at which the safe point is absent.
  // mode 0: a strobe marks the safe edge. mode 1: the generator is disabled at
  // the safe edge. mode 2: nothing is presented, and expiry forces the burst.
  task automatic run_burst(input int unsafe, input int mode);
    entry_t e;
    int n;
    for (int i = 0; i < unsafe; i++) begin
      fg_enable_i   = 1'b1;
      period_STRB_i = 1'b0;
      tick();
      check("wait_no_wr", cr_wr_o, 0);
      check("wait_busy", busy_o, 1);
      check("wait_ready", req_ready_o, 0);
    end
    case (mode)
      0: begin fg_enable_i = 1'b1; period_STRB_i = 1'b1; end
      1: begin fg_enable_i = 1'b0; end
      default: begin fg_enable_i = 1'b1; end
    endcase
    tick();
    period_STRB_i = 1'b0;
    check("safe_no_wr", cr_wr_o, 0);
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = mq.pop_front();
      last_a = e.a;
      last_d = e.d;
      check("wr_strobe", cr_wr_o, 1);
      check("wr_addr", cr_addr_o, e.a);
      check("wr_data", cr_data_o, e.d);
      check("wr_busy", busy_o, 1);
    end
    tick();
    check("end_no_wr", cr_wr_o, 0);
    check("end_busy", busy_o, 0);
    check("end_ready", req_ready_o, 1);
    check("end_count", count_o, 0);
    check("hold_addr", cr_addr_o, last_a);
    check("hold_data", cr_data_o, last_d);
    check("timeout_flag", timeout_o, exp_to);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, cr_wr_o, 0);
    check({tag, "_addr"}, cr_addr_o, 0);
    check({tag, "_data"}, cr_data_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_addr_o, 0);
    check({tag, "_to"}, timeout_o, 0);
  endtask

  initial begin
    int n, mode, unsafe;
    bit cw;
    entry_t e;
    n_chk = 0;
    n_pass = 0;
    exp_err = 1'b0;
    exp_to = 1'b0;
    last_a = '0;
    last_d = '0;
    rstn_i = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_data_i = '0;
    commit_i = 1'b0;
    fg_enable_i = 1'b0;
    period_STRB_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    check("rst_ready", req_ready_o, 1);
    rstn_i = 1'b1;
    tick();

    // Generator disabled: two entries then commit
    fg_enable_i = 1'b0;
    do_push(3'd0, 8'h54, 1'b0);
    do_push(3'd5, 8'h32, 1'b0);
    do_commit();
    run_burst(0, 1);

    // Generator running: strobe well after commit, IDLE strobe not remembered
    fg_enable_i = 1'b1;
    period_STRB_i = 1'b1;
    tick();
    period_STRB_i = 1'b0;
    do_push(3'd1, 8'hA1, 1'b0);
    do_push(3'd2, 8'hB2, 1'b0);
    do_push(3'd2, 8'hC3, 1'b0);
    do_commit();
`ifdef FG_CFG_TIMEOUT_EN
    run_burst(14, 0);
`else
    run_burst(19, 0);
`endif

    // Full queue, refused fifth request, then a wrapped second burst
    for (int i = 0; i < 4; i++) do_push(ADDR_W'(i + 2), DATA_W'(8'h10 + i), 1'b0);
    do_push(3'd6, 8'hEE, 1'b0);
    do_commit();
    run_burst(0, 1);
    for (int i = 0; i < 4; i++) do_push(ADDR_W'(6 - i), DATA_W'(8'h80 + i), 1'b0);
    do_commit();
    run_burst(2, 1);

    // Invalid address is dropped; commit on empty queue is ignored
    do_push(3'd7, 8'h99, 1'b0);
    do_commit();
    tick();
    check("empty_commit_busy", busy_o, 0);

    // Push and commit in the same cycle
    fg_enable_i = 1'b0;
    do_push(3'd4, 8'h5A, 1'b1);
    run_burst(0, 1);

    // Randomized bursts
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      mode = $urandom_range(0, 1);
      unsafe = $urandom_range(0, 10);
      cw = 1'($urandom_range(0, 1));
      if (mode == 0) begin
        fg_enable_i = 1'b1;
        period_STRB_i = 1'b1;
        tick();
        period_STRB_i = 1'b0;
        check("idle_strb_busy", busy_o, 0);
      end
      for (int j = 0; j < n; j++)
        do_push(ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom), cw && (j == n - 1));
      if (!cw) do_commit();
      if (mq.size() > 0) run_burst(unsafe, mode);
    end

    // Reset in the middle of a four-entry burst after two writes
    fg_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) do_push(ADDR_W'(i), DATA_W'(8'hC0 + i), 1'b0);
    do_commit();
    tick();
    check("mid_safe_no_wr", cr_wr_o, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = mq.pop_front();
      check("mid_wr_addr", cr_addr_o, e.a);
      check("mid_wr_data", cr_data_o, e.d);
    end
    rstn_i = 1'b0;
    #1;
    mq.delete();
    exp_err = 1'b0;
    exp_to = 1'b0;
    last_a = '0;
    last_d = '0;
    check_reset_outputs("mid_rst");
    #2;
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_wr", cr_wr_o, 0);
      check("post_rst_count", count_o, 0);
    end

    // Safe-point wait limit
`ifdef FG_CFG_TIMEOUT_EN
    fg_enable_i = 1'b1;
    do_push(3'd1, 8'h11, 1'b0);
    do_commit();
    run_burst(15, 0);
    do_push(3'd2, 8'h22, 1'b0);
    do_push(3'd3, 8'h33, 1'b0);
    do_commit();
    exp_to = 1'b1;
    run_burst(15, 2);
`else
    fg_enable_i = 1'b1;
    do_push(3'd2, 8'h22, 1'b0);
    do_push(3'd3, 8'h33, 1'b0);
    do_commit();
    run_burst(40, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
